// File: rtl/nios2_ocimem_arbiter.sv
// nios2_ocimem_arbiter: OCI debug RAM controller shared by JTAG and Avalon.
// Define OCIMEM_JTAG_PRIORITY_EN to make JTAG win every IDLE contention.
module nios2_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_JWR,
        S_JRD,
        S_JRD_CAP,
        S_ARD,
        S_ARD_CAP,
        S_AWR
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t              state_q;
    logic [ADDR_W-1:0]   jtag_addr_q;
    logic                jpend_q;
    logic                jwr_q;
    logic [DATA_W-1:0]   jdata_q;
    logic                last_avs_q;
    logic [DATA_W-1:0]   mon_q;
    logic                ready_q;
    logic                err_q;
    logic                wait_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wdata_q;

    logic                jbusy;
    logic                strobe_any;
    logic                areq;
    logic                gnt_j;
    logic                gnt_a;
    logic [ADDR_W-1:0]   jtag_addr_inc;
    logic                unused_jdo;

    assign unused_jdo = &{1'b0, jdo[37:35], jdo[2:0]};

    // A JTAG request occupies the single pending slot until its RAM access ends
    assign jbusy = jpend_q
                 | (state_q == S_JWR)
                 | (state_q == S_JRD)
                 | (state_q == S_JRD_CAP);

    assign strobe_any = take_action_ocimem_a
                      | take_action_ocimem_b
                      | take_no_action_ocimem_a;

    assign areq = avs_read | avs_write;

    assign jtag_addr_inc = jtag_addr_q + ADDR_ONE;

`ifdef OCIMEM_JTAG_PRIORITY_EN
    assign gnt_j = (state_q == S_IDLE) & jpend_q;
`else
    assign gnt_j = (state_q == S_IDLE) & jpend_q & (~areq | last_avs_q);
`endif
    assign gnt_a = (state_q == S_IDLE) & areq & ~gnt_j;

    // Read data is forwarded straight from the RAM in the completing cycle
    assign avs_readdata    = (state_q == S_ARD_CAP) ? ram_rdata : rdata_q;
    assign avs_waitrequest = wait_q;
    assign ram_addr        = ram_addr_q;
    assign ram_we          = ram_we_q;
    assign ram_wdata       = ram_wdata_q;
    assign MonDReg         = mon_q;
    assign monitor_ready   = ready_q;
    assign monitor_error   = err_q;

    // JTAG strobe intake, arbitration and RAM sequencing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            jtag_addr_q <= '0;
            jpend_q     <= 1'b0;
            jwr_q       <= 1'b0;
            jdata_q     <= '0;
            last_avs_q  <= 1'b0;
            mon_q       <= '0;
            ready_q     <= 1'b1;
            err_q       <= 1'b0;
            wait_q      <= 1'b1;
            rdata_q     <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_we_q <= 1'b0;
            wait_q   <= 1'b1;

            if (strobe_any && jbusy) begin
                err_q <= 1'b1;
            end else if (take_action_ocimem_a) begin
                jtag_addr_q <= jdo[ADDR_W+16:17];
                if (jdo[34]) begin
                    err_q <= 1'b0;
                end
            end else if (take_action_ocimem_b) begin
                jpend_q <= 1'b1;
                jwr_q   <= 1'b1;
                jdata_q <= jdo[34:3];
                ready_q <= 1'b0;
            end else if (take_no_action_ocimem_a) begin
                jpend_q <= 1'b1;
                jwr_q   <= 1'b0;
                ready_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (gnt_j) begin
                        jpend_q    <= 1'b0;
                        last_avs_q <= 1'b0;
                        ram_addr_q <= jtag_addr_q;
                        if (jwr_q) begin
                            ram_we_q    <= 1'b1;
                            ram_wdata_q <= jdata_q;
                            state_q     <= S_JWR;
                        end else begin
                            state_q <= S_JRD;
                        end
                    end else if (gnt_a) begin
                        last_avs_q <= 1'b1;
                        ram_addr_q <= avs_address;
                        if (avs_write) begin
                            ram_we_q    <= 1'b1;
                            ram_wdata_q <= avs_writedata;
                            wait_q      <= 1'b0;
                            state_q     <= S_AWR;
                        end else begin
                            state_q <= S_ARD;
                        end
                    end
                end
                S_JWR: begin
                    jtag_addr_q <= jtag_addr_inc;
                    ready_q     <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_JRD: begin
                    state_q <= S_JRD_CAP;
                end
                S_JRD_CAP: begin
                    mon_q       <= ram_rdata;
                    jtag_addr_q <= jtag_addr_inc;
                    ready_q     <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_ARD: begin
                    wait_q  <= 1'b0;
                    state_q <= S_ARD_CAP;
                end
                S_ARD_CAP: begin
                    rdata_q <= ram_rdata;
                    state_q <= S_IDLE;
                end
                S_AWR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// tb_nios2_ocimem_arbiter: directed + random bench for the OCI RAM arbiter.
// Reference keeps RAM image, JTAG address and error flag as plain variables.
module tb_nios2_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a, take_b, take_na;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata, ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    logic [31:0] tb_mem [256];
    logic        mem_clr;

    logic [31:0] ref_mem [256];
    logic [7:0]  ref_jaddr;
    logic        ref_err;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_na),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_we                  (ram_we),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    // Single-port RAM with one cycle registered read latency
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (ram_we) tb_mem[ram_addr] <= ram_wdata;
            ram_rdata <= tb_mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst();
        chk("rst_mon",   MonDReg, 32'h0);
        chk("rst_rdy",   monitor_ready, 1);
        chk("rst_err",   monitor_error, 0);
        chk("rst_wait",  avs_waitrequest, 1);
        chk("rst_rdata", avs_readdata, 32'h0);
        chk("rst_we",    ram_we, 0);
        chk("rst_addr",  ram_addr, 0);
        chk("rst_wdata", ram_wdata, 32'h0);
    endtask

    task automatic chk_mem(input string tag);
        int nbad;
        nbad = 0;
        for (int i = 0; i < 256; i++)
            if (tb_mem[i] !== ref_mem[i]) nbad++;
        chk(tag, nbad, 0);
    endtask

    task automatic jtag_seta(input logic [7:0] a, input logic clr);
        tick();
        jdo = '0;
        jdo[24:17] = a;
        jdo[34] = clr;
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
        ref_jaddr = a;
        if (clr) ref_err = 1'b0;
        chk("seta_rdy", monitor_ready, 1);
        chk("seta_err", monitor_error, ref_err);
    endtask

    task automatic jtag_write(input logic [31:0] d);
        logic [7:0] a;
        a = ref_jaddr;
        tick();
        jdo = '0;
        jdo[34:3] = d;
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        chk("jw_busy", monitor_ready, 0);
        tick();
        chk("jw_we", ram_we, 1);
        chk("jw_addr", ram_addr, a);
        chk("jw_data", ram_wdata, d);
        tick();
        chk("jw_rdy", monitor_ready, 1);
        ref_mem[a] = d;
        ref_jaddr = a + 8'd1;
    endtask

    task automatic jtag_read();
        logic [7:0] a;
        a = ref_jaddr;
        tick();
        jdo = '0;
        take_na = 1'b1;
        tick();
        take_na = 1'b0;
        chk("jr_busy1", monitor_ready, 0);
        tick();
        chk("jr_addr", ram_addr, a);
        chk("jr_we", ram_we, 0);
        tick();
        chk("jr_busy3", monitor_ready, 0);
        tick();
        chk("jr_mon", MonDReg, ref_mem[a]);
        chk("jr_rdy", monitor_ready, 1);
        ref_jaddr = a + 8'd1;
    endtask

    task automatic avs_wr(input logic [7:0] a, input logic [31:0] d);
        tick();
        avs_write = 1'b1;
        avs_address = a;
        avs_writedata = d;
        chk("aw_wait0", avs_waitrequest, 1);
        tick();
        chk("aw_wait1", avs_waitrequest, 0);
        chk("aw_we", ram_we, 1);
        chk("aw_addr", ram_addr, a);
        chk("aw_data", ram_wdata, d);
        tick();
        avs_write = 1'b0;
        chk("aw_wait2", avs_waitrequest, 1);
        ref_mem[a] = d;
    endtask

    task automatic avs_rd(input logic [7:0] a);
        tick();
        avs_read = 1'b1;
        avs_address = a;
        chk("ar_wait0", avs_waitrequest, 1);
        tick();
        chk("ar_wait1", avs_waitrequest, 1);
        chk("ar_addr", ram_addr, a);
        tick();
        chk("ar_wait2", avs_waitrequest, 0);
        chk("ar_data", avs_readdata, ref_mem[a]);
        tick();
        avs_read = 1'b0;
        chk("ar_hold", avs_readdata, ref_mem[a]);
    endtask

    initial begin
        int wcyc, jcyc, exp_w, exp_j, nwe;
        bit drop;
        logic [31:0] d;

        reset_n = 1'b0;
        jdo = '0;
        take_a = 1'b0;
        take_b = 1'b0;
        take_na = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        mem_clr = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_jaddr = '0;
        ref_err = 1'b0;

        repeat (3) tick();
        mem_clr = 1'b0;
        chk_rst();
        reset_n = 1'b1;

        // JTAG write at 0x10, then read proves the address moved to 0x11
        jtag_seta(8'h10, 1'b0);
        jtag_write(32'hDEADBEEF);
        jtag_read();

        // Read at 0xFF wraps the JTAG address to 0x00
        avs_wr(8'h20, 32'hCAFE0020);
        avs_wr(8'hFF, 32'h12345678);
        jtag_seta(8'hFF, 1'b0);
        jtag_read();
        jtag_write(32'h0BADF00D);

        // Contention: JTAG write pending while Avalon read arrives
`ifdef OCIMEM_JTAG_PRIORITY_EN
        exp_w = 5;
        exp_j = 2;
`else
        exp_w = 3;
        exp_j = 5;
`endif
        wcyc = -1;
        jcyc = -1;
        drop = 1'b0;
        tick();
        jdo = '0;
        jdo[34:3] = 32'h22222222;
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        avs_read = 1'b1;
        avs_address = 8'h20;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) tick();
            if (drop) begin
                avs_read = 1'b0;
                drop = 1'b0;
            end
            if (avs_waitrequest == 1'b0 && wcyc < 0) begin
                wcyc = c;
                chk("arb_rdata", avs_readdata, 32'hCAFE0020);
                drop = 1'b1;
            end
            if (ram_we && jcyc < 0) begin
                jcyc = c;
                chk("arb_jaddr", ram_addr, ref_jaddr);
                chk("arb_jdata", ram_wdata, 32'h22222222);
            end
        end
        avs_read = 1'b0;
        chk("arb_avs_cyc", wcyc, exp_w);
        chk("arb_jtag_cyc", jcyc, exp_j);
        ref_mem[ref_jaddr] = 32'h22222222;
        ref_jaddr = ref_jaddr + 8'd1;

        // Second write strobe while busy is dropped
        jtag_seta(8'h40, 1'b0);
        nwe = 0;
        tick();
        jdo = '0;
        jdo[34:3] = 32'hAAAA0001;
        take_b = 1'b1;
        tick();
        jdo[34:3] = 32'hBBBB0002;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) tick();
            if (c == 2) take_b = 1'b0;
            if (ram_we) begin
                nwe++;
                chk("dbl_addr", ram_addr, 8'h40);
                chk("dbl_data", ram_wdata, 32'hAAAA0001);
            end
        end
        chk("dbl_nwe", nwe, 1);
        ref_mem[8'h40] = 32'hAAAA0001;
        ref_jaddr = 8'h41;
        ref_err = 1'b1;
        chk("dbl_err", monitor_error, 1);
        jtag_seta(8'h60, 1'b1);

        // Address load while a read is in flight is dropped
        tick();
        jdo = '0;
        take_na = 1'b1;
        tick();
        take_na = 1'b0;
        jdo[24:17] = 8'h77;
        take_a = 1'b1;
        tick();
        take_a = 1'b0;
        tick();
        tick();
        chk("busy_a_mon", MonDReg, ref_mem[8'h60]);
        chk("busy_a_err", monitor_error, 1);
        ref_jaddr = 8'h61;
        ref_err = 1'b1;
        jtag_write(32'h61616161);
        jtag_seta(8'h00, 1'b1);

        // Avalon write then read back
        avs_wr(8'h03, 32'hA5A5A5A5);
        avs_rd(8'h03);

        // Reset in the middle of a JTAG read
        jtag_seta(8'h05, 1'b0);
        tick();
        jdo = '0;
        take_na = 1'b1;
        tick();
        take_na = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk_rst();
        tick();
        chk_rst();
        reset_n = 1'b1;
        ref_jaddr = '0;
        ref_err = 1'b0;
        tick();
        chk("post_rst_rdy", monitor_ready, 1);
        chk_mem("post_rst_mem");
        jtag_write(32'h0000C0DE);

        // Random sequential traffic against the reference
        for (int n = 0; n < 120; n++) begin
            d = $urandom;
            case ($urandom_range(0, 4))
                0: jtag_seta(8'($urandom_range(0, 255)),
                             1'($urandom_range(0, 1)));
                1: jtag_write(d);
                2: jtag_read();
                3: avs_wr(8'($urandom_range(0, 255)), d);
                default: avs_rd(8'($urandom_range(0, 255)));
            endcase
        end
        tick();
        chk("rnd_err", monitor_error, ref_err);
        chk_mem("final_mem");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/nios2_ocimem_arbiter.md
Name: nios2_ocimem_arbiter

Overview:
- Controller and arbiter for the Nios II on-chip debug memory (OCI RAM).
- Shares one single-port RAM between two requesters:
  - the JTAG debug path, which issues take_action/take_no_action strobes with jdo in the clk domain;
  - the CPU debug-slave Avalon-MM port.
- Sequences JTAG reads and writes with address auto-increment, returns read data on MonDReg, and drives the monitor_ready/monitor_error status that the JTAG TCK logic scans out.

Parameters:
- ADDR_W, 8, OCI RAM word-address width (256 x 32-bit words).
- DATA_W, 32, RAM/Avalon data width. Fixed at 32 because of the jdo field layout.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  JTAG data word, already synchronised to clk.
- take_action_ocimem_a  in  1  1-cycle strobe: load JTAG address.
- take_action_ocimem_b  in  1  1-cycle strobe: JTAG write, then increment address.
- take_no_action_ocimem_a  in  1  1-cycle strobe: JTAG read, then increment address.
- avs_address  in  ADDR_W  Avalon word address.
- avs_read  in  1  Avalon read request.
- avs_write  in  1  Avalon write request.
- avs_writedata  in  32  Avalon write data.
- avs_readdata  out  32  Avalon read data, valid when avs_read=1 and avs_waitrequest=0.
- avs_waitrequest  out  1  Avalon stall.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, 1-cycle registered latency.
- MonDReg  out  32  last JTAG read data.
- monitor_ready  out  1  JTAG side has no request outstanding.
- monitor_error  out  1  sticky flag: a JTAG request was dropped.

Behaviour:
- Reset values: MonDReg=0, monitor_ready=1, monitor_error=0, avs_waitrequest=1, avs_readdata=0, ram_we=0, ram_addr=0, ram_wdata=0, jtag_addr=0, last_grant=JTAG, state=IDLE.
- ocimem_a:
  - jtag_addr <= jdo[ADDR_W+16:17].
  - If jdo[34]=1, also clear monitor_error.
  - Completes in 1 cycle and never touches the RAM.
- ocimem_b:
  - Latches a pending write with data jdo[34:3].
  - monitor_ready <= 0 on the cycle after the strobe.
- no_action_ocimem_a:
  - Latches a pending read.
  - monitor_ready <= 0 on the cycle after the strobe.
- Pending request depth is one.
  - A b or no_action strobe arriving while a request is pending or in service is dropped and sets monitor_error=1.
  - An ocimem_a strobe arriving while busy is also dropped, sets monitor_error=1, and leaves jtag_addr unchanged.
- FSM states: IDLE, JWR, JRD, JRD_CAP, ARD, ARD_CAP, AWR.
- IDLE arbitration, decided combinationally each cycle:
  - Only JTAG pending: grant JTAG.
  - Only Avalon requesting: grant Avalon.
  - Both: round-robin; grant the requester opposite to last_grant.
  - avs_read and avs_write both high: treated as a write.
- JWR (1 cycle):
  - ram_we=1, ram_addr=jtag_addr, ram_wdata=data.
  - jtag_addr increments modulo 2^ADDR_W (0xFF wraps to 0x00).
  - monitor_ready <= 1. Next state IDLE.
- JRD:
  - ram_addr=jtag_addr. Next state JRD_CAP.
- JRD_CAP:
  - MonDReg <= ram_rdata, jtag_addr increments (wrapping), monitor_ready <= 1. Next state IDLE.
- AWR:
  - ram_we=1, ram_addr=avs_address, ram_wdata=avs_writedata.
  - avs_waitrequest=0 in this cycle. Next state IDLE.
- ARD then ARD_CAP:
  - avs_readdata <= ram_rdata at the end of ARD_CAP.
  - avs_waitrequest=0 in ARD_CAP.
- avs_waitrequest=1 in every other cycle.
- Avalon inputs must be held stable while avs_waitrequest=1.
- last_grant updates on every grant.
- Latency, measured from a strobe in cycle 0 with no contention:
  - JTAG write: RAM written in cycle 2.
  - JTAG read: MonDReg valid and monitor_ready=1 from cycle 4.
  - Avalon write: completes in cycle 1 (waitrequest low in cycle 1).
  - Avalon read: completes in cycle 2.
- A reset assertion mid-transaction aborts it immediately. No RAM write is issued after reset is asserted.

Optional Feature:
- Macro: OCIMEM_JTAG_PRIORITY_EN.
- Defined: on contention in IDLE, JTAG always wins and last_grant is ignored. Avalon can starve only while JTAG requests are back-to-back, which the strobe rate bounds.
- Undefined: round-robin arbitration as specified above.

Test Plan:
- ocimem_a with jdo[ADDR_W+16:17]=0x10, then ocimem_b with data 0xDEADBEEF -> RAM[0x10]=0xDEADBEEF, jtag_addr=0x11, monitor_ready back to 1 in cycle 3.
- Address 0xFF, then no_action_ocimem_a with RAM[0xFF]=0x12345678 -> MonDReg=0x12345678, jtag_addr wraps to 0x00.
- Avalon read of 0x20 issued in the same cycle a JTAG write becomes pending, last_grant=JTAG -> Avalon served first (waitrequest low 2 cycles later), JTAG write follows. With OCIMEM_JTAG_PRIORITY_EN defined -> JTAG write first.
- Two ocimem_b strobes 1 cycle apart -> second dropped, monitor_error=1, exactly one RAM write. Then ocimem_a with jdo[34]=1 -> monitor_error=0.
- Avalon write 0xA5A5A5A5 to 0x03, then Avalon read of 0x03 -> avs_readdata=0xA5A5A5A5, waitrequest pattern 0, then 1,0.
- reset_n asserted during JRD -> all outputs at reset values. After release, RAM contents unchanged and monitor_ready=1.
